// File: rtl/chicken_pkg.sv
// Shared definitions for the Chicken Cha-Cha-Cha board logic.
package chicken_pkg;

    // Turn-controller states; encoding 7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        REVEAL = 3'd2,
        MOVE   = 3'd3,
        SETTLE = 3'd4,
        PASS   = 3'd5,
        OVER   = 3'd6
    } state_t;

    // Player index width and upper player bound, shared with the win-check stage.
    localparam int PLAYER_W    = 2;
    localparam int MAX_PLAYERS = 4;

endpackage

// File: rtl/btn_edge.sv
// Front-panel button conditioner: 2-flop synchronizer and rising-edge
// detector. A raw rise shows up as a one-cycle press 3 cycles later.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic press_reg;

    // Synchronize the raw button and register a single pulse per rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            press_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/turn_controller.sv
// Game sequencer: turns button presses and the card-match result into the
// turn index T and the move strobe B, and locks the game once a win is seen.
module turn_controller
    import chicken_pkg::*;
#(
    parameter int NUM_PLAYERS   = 4,
    parameter int REVEAL_CYCLES = 50000000,
    parameter int TURN_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn,
    input  logic                  match,
    input  logic                  win,
    output logic [PLAYER_W-1:0]   T,
    output logic                  B,
    output logic                  reveal,
    output logic                  game_over,
    output logic [TURN_CNT_W-1:0] turn_cnt
);

    localparam int TIMER_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(REVEAL_CYCLES - 1);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);

    logic press;

    state_t                state_reg,  state_next;
    logic [PLAYER_W-1:0]   t_reg,      t_next;
    logic [TURN_CNT_W-1:0] cnt_reg,    cnt_next;
    logic [TIMER_W-1:0]    timer_reg,  timer_next;
    logic                  match_reg,  match_next;
    logic                  b_reg,      b_next;
    logic                  reveal_reg, reveal_next;
    logic                  over_reg,   over_next;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    // State, datapath and registered (Moore) outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            t_reg      <= '0;
            cnt_reg    <= '0;
            timer_reg  <= '0;
            match_reg  <= 1'b0;
            b_reg      <= 1'b0;
            reveal_reg <= 1'b0;
            over_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            cnt_reg    <= cnt_next;
            timer_reg  <= timer_next;
            match_reg  <= match_next;
            b_reg      <= b_next;
            reveal_reg <= reveal_next;
            over_reg   <= over_next;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // register in the same cycle the state is entered.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        cnt_next   = cnt_reg;
        timer_next = timer_reg;
        match_next = match_reg;

        case (state_reg)
            IDLE: begin
                // The game-start press only opens the first turn.
                if (press) state_next = PICK;
            end
            PICK: begin
                if (press) begin
                    match_next = match;
                    timer_next = TIMER_LOAD;
                    state_next = REVEAL;
                end
            end
            REVEAL: begin
                if (timer_reg == '0) begin
                    state_next = match_reg ? MOVE : PASS;
                end else begin
                    timer_next = timer_reg - TIMER_W'(1);
                end
            end
            MOVE: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                // Downstream has had a cycle to update W; a correct guess keeps the turn.
                state_next = win ? OVER : PICK;
            end
            PASS: begin
                t_next     = (t_reg == LAST_PLAYER) ? '0 : t_reg + PLAYER_W'(1);
                cnt_next   = (&cnt_reg) ? cnt_reg : cnt_reg + TURN_CNT_W'(1);
                state_next = PICK;
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        b_next      = (state_next == MOVE);
        reveal_next = (state_next == REVEAL);
        over_next   = (state_next == OVER);
    end

    assign T         = t_reg;
    assign B         = b_reg;
    assign reveal    = reveal_reg;
    assign game_over = over_reg;
    assign turn_cnt  = cnt_reg;

endmodule

// File: tb/tb_turn_controller.sv
// Directed testbench for turn_controller (REVEAL_CYCLES = 4); a second
// 3-player instance shares the stimulus to check the short rotation.
module tb_turn_controller;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       match;
    logic       win;
    logic [1:0] T,  T3;
    logic       B,  B3;
    logic       reveal, reveal3;
    logic       game_over, game_over3;
    logic [7:0] turn_cnt, turn_cnt3;

    int tests;
    int fails;

    // per-window observation counters
    int rv_cnt, rv_rises, b_cnt, rv_first, b_first, go_first;
    logic rv_prev;

    turn_controller #(.NUM_PLAYERS(4), .REVEAL_CYCLES(4), .TURN_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .btn(btn), .match(match), .win(win),
        .T(T), .B(B), .reveal(reveal), .game_over(game_over), .turn_cnt(turn_cnt)
    );

    turn_controller #(.NUM_PLAYERS(3), .REVEAL_CYCLES(4), .TURN_CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .btn(btn), .match(match), .win(win),
        .T(T3), .B(B3), .reveal(reveal3), .game_over(game_over3), .turn_cnt(turn_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_obs();
        rv_cnt = 0; rv_rises = 0; b_cnt = 0;
        rv_first = -1; b_first = -1; go_first = -1;
        rv_prev = 1'b0;
    endtask

    task automatic sample(input int i);
        if (reveal) rv_cnt++;
        if (reveal && !rv_prev) begin
            rv_rises++;
            if (rv_first < 0) rv_first = i;
        end
        rv_prev = reveal;
        if (B) begin
            b_cnt++;
            if (b_first < 0) b_first = i;
        end
        if (game_over && go_first < 0) go_first = i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; btn = 1'b0; match = 1'b0; win = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_game();
        @(negedge clk); btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // One press with the given match/win levels, observed for nc cycles.
    task automatic pick(input logic m, input logic w, input int nc);
        match = m; win = w;
        clear_obs();
        @(negedge clk); btn = 1'b1;
        for (int i = 0; i < nc; i++) begin
            @(negedge clk);
            if (i == 1) btn = 1'b0;
            sample(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; btn = 1'b0; match = 1'b0; win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn = ~btn;
            tests++;
            if ({T, B, reveal, game_over, turn_cnt} !== 13'd0) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: T=%0d B=%b reveal=%b go=%b cnt=%0d, required all 0",
                         i, T, B, reveal, game_over, turn_cnt);
            end
        end
        @(negedge clk); btn = 1'b0; rst = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if ({T, B, reveal, game_over, turn_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_release: T=%0d B=%b reveal=%b go=%b cnt=%0d, required all 0",
                     T, B, reveal, game_over, turn_cnt);
        end
        $display("[TB] reset: outputs held at zero through reset and release");
    endtask

    task automatic test_miss();
        start_game();
        tests++;
        if (reveal !== 1'b0 || T !== 2'd0) begin
            fails++;
            $display("FAIL start_press: reveal=%b T=%0d, required reveal=0 T=0", reveal, T);
        end
        pick(1'b0, 1'b0, 20);
        tests++;
        if (rv_cnt != 4 || rv_rises != 1) begin
            fails++;
            $display("FAIL miss_reveal: reveal cycles=%0d windows=%0d, required 4 and 1", rv_cnt, rv_rises);
        end
        tests++;
        if (b_cnt != 0) begin
            fails++;
            $display("FAIL miss_b: B pulses=%0d, required 0", b_cnt);
        end
        tests++;
        if (T !== 2'd1 || turn_cnt !== 8'd1 || T3 !== 2'd1) begin
            fails++;
            $display("FAIL miss_turn: T=%0d cnt=%0d T3=%0d, required T=1 cnt=1 T3=1", T, turn_cnt, T3);
        end
        $display("[TB] miss: reveal=%0d cycles, B=%0d, T=%0d, turn_cnt=%0d", rv_cnt, b_cnt, T, turn_cnt);
    endtask

    task automatic test_hit();
        pick(1'b1, 1'b0, 20);
        tests++;
        if (b_cnt != 1) begin
            fails++;
            $display("FAIL hit_b_count: B pulses=%0d, required 1", b_cnt);
        end
        tests++;
        if (rv_cnt != 4 || (b_first - rv_first) != 4) begin
            fails++;
            $display("FAIL hit_b_timing: reveal=%0d, B offset from reveal rise=%0d, required 4 and 4",
                     rv_cnt, b_first - rv_first);
        end
        tests++;
        if (T !== 2'd1 || turn_cnt !== 8'd1 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL hit_turn: T=%0d cnt=%0d go=%b, required T=1 cnt=1 go=0", T, turn_cnt, game_over);
        end
        $display("[TB] hit: B=%0d at +%0d after reveal, T=%0d, turn_cnt=%0d",
                 b_cnt, b_first - rv_first, T, turn_cnt);
    endtask

    task automatic test_win_in_pick();
        win = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (game_over !== 1'b0) begin
            fails++;
            $display("FAIL win_in_pick: game_over=%b, required 0", game_over);
        end
        pick(1'b0, 1'b1, 20);
        tests++;
        if (game_over !== 1'b0 || T !== 2'd2 || turn_cnt !== 8'd2) begin
            fails++;
            $display("FAIL win_on_miss: go=%b T=%0d cnt=%0d, required go=0 T=2 cnt=2", game_over, T, turn_cnt);
        end
        win = 1'b0;
        $display("[TB] win_in_pick: game_over=%b T=%0d", game_over, T);
    endtask

    task automatic test_wrap();
        logic [1:0] exp4 [4];
        logic [1:0] exp3 [4];
        exp4 = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp3 = '{2'd1, 2'd2, 2'd0, 2'd1};
        do_reset();
        start_game();
        for (int k = 0; k < 4; k++) begin
            pick(1'b0, 1'b0, 20);
            tests++;
            if (T !== exp4[k] || T3 !== exp3[k] || turn_cnt !== 8'(k + 1)) begin
                fails++;
                $display("FAIL wrap miss %0d: T=%0d T3=%0d cnt=%0d, required T=%0d T3=%0d cnt=%0d",
                         k, T, T3, turn_cnt, exp4[k], exp3[k], k + 1);
            end
            $display("[TB] wrap miss %0d: T=%0d T3=%0d turn_cnt=%0d", k, T, T3, turn_cnt);
        end
    endtask

    task automatic test_held_button();
        match = 1'b0;
        clear_obs();
        @(negedge clk); btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sample(i);
        end
        btn = 1'b0;
        for (int i = 100; i < 110; i++) begin
            @(negedge clk);
            sample(i);
        end
        tests++;
        if (rv_rises != 1 || rv_cnt != 4 || T !== 2'd1) begin
            fails++;
            $display("FAIL held_button: windows=%0d reveal=%0d T=%0d, required 1, 4, T=1", rv_rises, rv_cnt, T);
        end
        $display("[TB] held_button: windows=%0d T=%0d", rv_rises, T);
    endtask

    task automatic test_press_in_reveal();
        match = 1'b0;
        clear_obs();
        // Two short pulses: the second press lands while REVEAL is running.
        @(negedge clk); btn = 1'b1; sample(0);
        @(negedge clk); btn = 1'b0; sample(1);
        @(negedge clk); btn = 1'b1; sample(2);
        @(negedge clk); btn = 1'b0; sample(3);
        for (int i = 4; i < 24; i++) begin
            @(negedge clk);
            sample(i);
        end
        tests++;
        if (rv_rises != 1 || rv_cnt != 4 || T !== 2'd2 || turn_cnt !== 8'd6) begin
            fails++;
            $display("FAIL press_in_reveal: windows=%0d reveal=%0d T=%0d cnt=%0d, required 1, 4, T=2, cnt=6",
                     rv_rises, rv_cnt, T, turn_cnt);
        end
        $display("[TB] press_in_reveal: windows=%0d T=%0d turn_cnt=%0d", rv_rises, T, turn_cnt);
    endtask

    task automatic test_reset_mid_reveal();
        int seen;
        seen = 0;
        match = 1'b1;
        @(negedge clk); btn = 1'b1;
        @(negedge clk);
        @(negedge clk); btn = 1'b0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (reveal) seen = 1;
        end
        tests++;
        if (seen == 0) begin
            fails++;
            $display("FAIL mid_reveal_start: reveal never rose within 10 cycles, required rise");
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (reveal !== 1'b0 || T !== 2'd0 || turn_cnt !== 8'd0 || B !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: reveal=%b T=%0d cnt=%0d B=%b, required all 0", reveal, T, turn_cnt, B);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample(i);
        end
        tests++;
        if (b_cnt != 0 || rv_cnt != 0) begin
            fails++;
            $display("FAIL after_reset: B pulses=%0d reveal=%0d, required 0 and 0", b_cnt, rv_cnt);
        end
        match = 1'b0;
        $display("[TB] reset_mid_reveal: B after reset=%0d", b_cnt);
    endtask

    task automatic test_game_over();
        start_game();
        pick(1'b0, 1'b0, 20);
        pick(1'b1, 1'b1, 20);
        tests++;
        if (b_cnt != 1 || go_first < 0 || (go_first - b_first) != 2) begin
            fails++;
            $display("FAIL win_timing: B=%0d game_over offset from B=%0d, required 1 and 2",
                     b_cnt, go_first - b_first);
        end
        tests++;
        if (game_over !== 1'b1 || T !== 2'd1 || turn_cnt !== 8'd1) begin
            fails++;
            $display("FAIL win_state: go=%b T=%0d cnt=%0d, required go=1 T=1 cnt=1", game_over, T, turn_cnt);
        end
        win = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pick(1'b1, 1'b0, 12);
            tests++;
            if (rv_cnt != 0 || b_cnt != 0 || T !== 2'd1 || turn_cnt !== 8'd1 || game_over !== 1'b1) begin
                fails++;
                $display("FAIL over_press %0d: reveal=%0d B=%0d T=%0d cnt=%0d go=%b, required 0 0 1 1 1",
                         k, rv_cnt, b_cnt, T, turn_cnt, game_over);
            end
            $display("[TB] over_press %0d: reveal=%0d B=%0d T=%0d", k, rv_cnt, b_cnt, T);
        end
        do_reset();
        tests++;
        if (game_over !== 1'b0 || T !== 2'd0) begin
            fails++;
            $display("FAIL over_clear: go=%b T=%0d, required go=0 T=0", game_over, T);
        end
        $display("[TB] game_over cleared by reset: go=%b", game_over);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_miss();
        test_hit();
        test_win_in_pick();
        test_wrap();
        test_held_button();
        test_press_in_reveal();
        test_reset_mid_reveal();
        test_game_over();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
